// File: rtl/p_mac.sv
// p_mac: pipelined multiply-accumulate element for the matrix datapath.
// Input register -> MULT_LATENCY product registers -> accumulator/output.
// Accumulation groups are delimited by first/last tags. A single global
// advance signal stalls the whole pipe while a result waits for its consumer.
module p_mac #(
   parameter int WIDTH        = 8,
   parameter int MULT_LATENCY = 3,
   parameter int ACC_WIDTH    = 2*WIDTH+8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     dataa,
   input  logic [WIDTH-1:0]     datab,
   input  logic                 in_signed,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_res,
   output logic                 out_ovf
);

   localparam int          PW   = 2*WIDTH;
   localparam int unsigned TAIL = MULT_LATENCY - 1;

   logic                 advance;

   // input stage
   logic                 s0_valid;
   logic [WIDTH-1:0]     s0_a;
   logic [WIDTH-1:0]     s0_b;
   logic                 s0_signed;
   logic                 s0_first;
   logic                 s0_last;

   // product computed from the input stage
   logic [PW-1:0]        ext_a;
   logic [PW-1:0]        ext_b;
   logic [PW-1:0]        prod_w;
   logic [ACC_WIDTH-1:0] prod_x;

   // product pipeline
   logic                 p_valid  [MULT_LATENCY];
   logic [ACC_WIDTH-1:0] p_prod   [MULT_LATENCY];
   logic                 p_signed [MULT_LATENCY];
   logic                 p_first  [MULT_LATENCY];
   logic                 p_last   [MULT_LATENCY];

   // accumulator
   logic [ACC_WIDTH-1:0] acc;
   logic                 sticky;
   logic [ACC_WIDTH-1:0] acc_base;
   logic                 sticky_base;
   logic [ACC_WIDTH:0]   sum;
   logic                 add_ovf;
   logic [ACC_WIDTH-1:0] acc_next;
   logic                 sticky_next;

   // Global stall: hold everything while a result sits unconsumed.
   always_comb begin
      advance  = !(out_valid && !out_ready);
      in_ready = advance && !rst;
   end

   // Input stage capture; a bubble is captured as an invalid stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid  <= 1'b0;
         s0_a      <= '0;
         s0_b      <= '0;
         s0_signed <= 1'b0;
         s0_first  <= 1'b0;
         s0_last   <= 1'b0;
      end else if (advance) begin
         s0_valid  <= in_valid;
         s0_a      <= dataa;
         s0_b      <= datab;
         s0_signed <= in_signed;
         s0_first  <= in_first;
         s0_last   <= in_last;
      end
   end

   // Extend operands per beat mode; the low PW bits of the product are the
   // same for signed and unsigned once operands are extended to PW bits.
   always_comb begin
      if (s0_signed) begin
         ext_a = PW'($signed(s0_a));
         ext_b = PW'($signed(s0_b));
      end else begin
         ext_a = PW'(s0_a);
         ext_b = PW'(s0_b);
      end
      prod_w = ext_a * ext_b;
      if (s0_signed) begin
         prod_x = ACC_WIDTH'($signed(prod_w));
      end else begin
         prod_x = ACC_WIDTH'(prod_w);
      end
   end

   // Product pipeline carrying the product and its tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
            p_valid[i]  <= 1'b0;
            p_prod[i]   <= '0;
            p_signed[i] <= 1'b0;
            p_first[i]  <= 1'b0;
            p_last[i]   <= 1'b0;
         end
      end else if (advance) begin
         p_valid[0]  <= s0_valid;
         p_prod[0]   <= prod_x;
         p_signed[0] <= s0_signed;
         p_first[0]  <= s0_first;
         p_last[0]   <= s0_last;
         for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
            p_valid[i]  <= p_valid[i-1];
            p_prod[i]   <= p_prod[i-1];
            p_signed[i] <= p_signed[i-1];
            p_first[i]  <= p_first[i-1];
            p_last[i]   <= p_last[i-1];
         end
      end
   end

   // Next accumulator value and overflow check for the beat at the pipe tail.
   // A first beat adds onto zero, which can never overflow in either mode.
   always_comb begin
      acc_base    = p_first[TAIL] ? '0 : acc;
      sticky_base = p_first[TAIL] ? 1'b0 : sticky;
      sum         = {1'b0, acc_base} + {1'b0, p_prod[TAIL]};
      if (p_signed[TAIL]) begin
         add_ovf = (acc_base[ACC_WIDTH-1] == p_prod[TAIL][ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
      end else begin
         add_ovf = sum[ACC_WIDTH];
      end
      acc_next    = sum[ACC_WIDTH-1:0];
      sticky_next = sticky_base | add_ovf;
   end

   // Accumulator and sticky overflow update on every valid tail beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         sticky <= 1'b0;
      end else if (advance && p_valid[TAIL]) begin
         acc    <= acc_next;
         sticky <= sticky_next;
      end
   end

   // Result register: load on a last beat, otherwise drop once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_res   <= '0;
         out_ovf   <= 1'b0;
      end else if (advance) begin
         if (p_valid[TAIL] && p_last[TAIL]) begin
            out_valid <= 1'b1;
            out_res   <= acc_next;
            out_ovf   <= sticky_next;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_p_mac.sv
// Self-checking bench for p_mac (WIDTH=8, MULT_LATENCY=3, ACC_WIDTH=24).
module tb_p_mac;

   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    dataa;
   logic [7:0]    datab;
   logic          in_signed;
   logic          in_first;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_res;
   logic          out_ovf;

   p_mac #(.WIDTH(8), .MULT_LATENCY(3), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dataa(dataa), .datab(datab), .in_signed(in_signed),
      .in_first(in_first), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_res(out_res), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [AW-1:0] res;
      logic          ovf;
      string         tag;
   } exp_t;

   exp_t expq[$];
   int   pop_cyc[$];
   exp_t mon_e;

   typedef struct {
      logic [7:0]    a;
      logic [7:0]    b;
      bit            s;
      bit            f;
      bit            l;
      logic [AW-1:0] res;
      bit            ovf;
   } vec_t;

   function automatic void chk(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(logic [AW-1:0] r, bit o, string t);
      exp_t e;
      e.res = r;
      e.ovf = o;
      e.tag = t;
      expq.push_back(e);
   endfunction

   // Behavioural reference: integer arithmetic on the group sum.
   bit     model_on = 0;
   longint m_acc = 0;
   bit     m_ovf = 0;
   localparam longint M = longint'(1) << AW;

   function automatic void model_beat(logic [7:0] a, logic [7:0] b, bit s, bit f, bit l);
      longint p, sa, t;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'(a) * longint'(b);
      if (f) begin
         m_acc = 0;
         m_ovf = 0;
      end
      if (s) begin
         sa = (m_acc >= M/2) ? m_acc - M : m_acc;
         t  = sa + p;
         if (t > M/2 - 1 || t < -(M/2)) m_ovf = 1;
      end else begin
         if (m_acc + p >= M) m_ovf = 1;
      end
      m_acc = (m_acc + p) % M;
      if (m_acc < 0) m_acc += M;
      if (l) push_exp(m_acc[AW-1:0], m_ovf, "rand");
   endfunction

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic beat(input logic [7:0] a, input logic [7:0] b,
                       input bit s, input bit f, input bit l, output int waits);
      dataa = a; datab = b; in_signed = s; in_first = f; in_last = l;
      in_valid = 1'b1;
      waits = 0;
      #1;
      while (!in_ready) begin
         if (waits >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout: in_ready stuck at 0, want 1");
            finish_run();
         end
         @(posedge clk); #2;
         waits++;
      end
      @(posedge clk); #1;
      if (model_on) model_beat(a, b, s, f, l);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(string name);
      int n = 0;
      while (expq.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, " pending"}, expq.size(), 0);
   endtask

   // Scoreboard: every consumed result is compared in order.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected result: got %0h, want none", out_res);
         end else begin
            mon_e = expq.pop_front();
            chk({mon_e.tag, " res"}, out_res, mon_e.res);
            chk({mon_e.tag, " ovf"}, out_ovf, mon_e.ovf);
         end
         pop_cyc.push_back(cyc);
      end
   end

   bit rnd_bp = 0;
   always @(posedge clk) begin
      if (rnd_bp) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      vectors++;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

   vec_t tbl[$];

   initial begin
      int w, tot, lat, n;
      bit f;
      vec_t v;

      tbl = '{
         '{8'h80, 8'h7F, 1, 1, 0, 24'h0,      0},
         '{8'h03, 8'h04, 1, 0, 0, 24'h0,      0},
         '{8'hFF, 8'hFF, 1, 0, 1, 24'hFFC08D, 0},
         '{8'hFF, 8'h02, 0, 1, 1, 24'd510,    0},
         '{8'hFF, 8'h02, 1, 1, 1, 24'hFFFFFE, 0},
         '{8'h80, 8'h80, 1, 1, 1, 24'd16384,  0},
         '{8'hFF, 8'h01, 1, 1, 0, 24'h0,      0},
         '{8'h01, 8'h01, 0, 0, 1, 24'h0,      1},
         '{8'h01, 8'h01, 0, 0, 1, 24'd1,      1},
         '{8'h07, 8'h06, 0, 1, 1, 24'd42,     0},
         '{8'hFF, 8'hFF, 1, 1, 1, 24'd1,      0},
         '{8'h7F, 8'h80, 0, 1, 1, 24'd16256,  0}
      };

      rst = 1'b1;
      idle();
      dataa = '0; datab = '0; in_signed = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_res", out_res, 0);
      chk("reset out_ovf", out_ovf, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // latency, unsigned 255*255
      beat(8'hFF, 8'hFF, 0, 1, 1, w);
      idle();
      push_exp(24'd65025, 0, "lat");
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (out_valid && lat == 0) lat = k;
      end
      chk("latency", lat, 4);
      drain("lat");

      // table vectors
      foreach (tbl[i]) begin
         v = tbl[i];
         beat(v.a, v.b, v.s, v.f, v.l, w);
         if (v.l) push_exp(v.res, v.ovf, $sformatf("tbl%0d", i));
      end
      idle();
      drain("table");

      // streaming: 4 back-to-back groups of 2*3
      pop_cyc.delete();
      tot = 0;
      for (int g = 0; g < 4; g++) begin
         for (int b = 0; b < 4; b++) begin
            beat(8'd2, 8'd3, 0, b == 0, b == 3, w);
            tot += w;
            if (b == 3) push_exp(24'd24, 0, "stream");
         end
      end
      idle();
      drain("stream");
      chk("stream stalls", tot, 0);
      chk("stream pops", pop_cyc.size(), 4);
      for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
         chk("stream spacing", pop_cyc[i] - pop_cyc[i-1], 4);

      // backpressure with a full pipeline
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         beat(8'(10*i), 8'd1, 0, 1, 1, w);
         push_exp(24'(10*i), 0, "bp");
      end
      idle();
      for (int k = 0; k < 5; k++) begin
         chk("bp in_ready", in_ready, 0);
         chk("bp out_valid", out_valid, 1);
         chk("bp out_res", out_res, 10);
         @(posedge clk); #1;
      end
      pop_cyc.delete();
      out_ready = 1'b1;
      drain("bp");
      chk("bp pops", pop_cyc.size(), 5);
      for (int i = 1; i < 5 && i < pop_cyc.size(); i++)
         chk("bp handover", pop_cyc[i] - pop_cyc[i-1], 1);

      // unsigned overflow group, then clean group
      for (int i = 0; i < 259; i++) beat(8'hFF, 8'hFF, 0, i == 0, i == 258, w);
      push_exp(24'd64259, 1, "uovf");
      beat(8'd1, 8'd1, 0, 1, 1, w);
      push_exp(24'd1, 0, "after ovf");
      // signed overflow: 129*65025 unsigned then +127*127 signed
      for (int i = 0; i < 129; i++) beat(8'hFF, 8'hFF, 0, i == 0, 0, w);
      beat(8'h7F, 8'h7F, 1, 0, 1, w);
      push_exp(24'h803D82, 1, "sovf");
      idle();
      drain("ovf");

      // reset mid-group with a pending result and beats in flight
      out_ready = 1'b0;
      beat(8'd7, 8'd7, 0, 1, 1, w);
      beat(8'd9, 8'd9, 0, 1, 0, w);
      beat(8'd9, 8'd9, 0, 0, 0, w);
      idle();
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pre-reset out_res", out_res, 49);
      #2 rst = 1'b1;
      #1;
      chk("midrst out_valid", out_valid, 0);
      chk("midrst out_res", out_res, 0);
      chk("midrst out_ovf", out_ovf, 0);
      chk("midrst in_ready", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk) rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      beat(8'd2, 8'd2, 0, 0, 1, w);
      push_exp(24'd4, 0, "post-rst nofirst");
      beat(8'd5, 8'd5, 0, 1, 1, w);
      push_exp(24'd25, 0, "post-rst 5x5");
      idle();
      drain("rst");

      // randomized groups against the reference model, random backpressure
      model_on = 1;
      rnd_bp = 1;
      for (int g = 0; g < 60; g++) begin
         int len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            f = (b == 0) && (g == 0 || $urandom_range(0, 7) != 0);
            beat(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), f, b == len - 1, w);
            if ($urandom_range(0, 3) == 0) begin
               idle();
               @(posedge clk); #1;
            end
         end
      end
      idle();
      rnd_bp = 0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain("random");

      finish_run();
   end

endmodule
